// File: rtl/dual_issue_fetch_queue.sv
// Instruction FIFO between dual fetch and two-lane issue: up to two pushes and two takes
// per cycle, with the two oldest entries presented in program order on the D lanes.
module dual_issue_fetch_queue #(
   parameter int unsigned DEPTH    = 8,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [1:0]               i_fetch_valid,
   input  logic [31:0]              i_fetch_instr1,
   input  logic [31:0]              i_fetch_instr2,
   input  logic [31:0]              i_fetch_pc,
   output logic                     o_fetch_ready,
   input  logic [1:0]               i_issue_take,
   input  logic                     i_flush,
   output logic [31:0]              o_instruction_d1,
   output logic [31:0]              o_instruction_d2,
   output logic [31:0]              o_pc_d1,
   output logic [31:0]              o_pc_d2,
   output logic                     o_valid_d1,
   output logic                     o_valid_d2,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   r_instr [DEPTH];
   logic [31:0]   r_pc    [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic          w_ready;
   logic [1:0]    w_push;
   logic [1:0]    w_take_req;
   logic [1:0]    w_take;
   logic [AW-1:0] w_wr_ptr_p1;
   logic [AW-1:0] w_rd_ptr_p1;

   always_comb begin
      // Ready looks only at current occupancy; same-cycle takes are not credited.
      w_ready     = (r_count <= CW'(DEPTH - 2));
      w_push      = 2'd0;
      if (w_ready && i_fetch_valid[0]) begin
         w_push = i_fetch_valid[1] ? 2'd2 : 2'd1;
      end
      w_take_req  = i_issue_take[1] ? 2'd2 : i_issue_take;
      if (CW'(w_take_req) > r_count) begin
         w_take = r_count[1:0];
      end else begin
         w_take = w_take_req;
      end
      w_wr_ptr_p1 = r_wr_ptr + AW'(1);
      w_rd_ptr_p1 = r_rd_ptr + AW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_rd_ptr <= r_rd_ptr + AW'(w_take);
         r_wr_ptr <= r_wr_ptr + AW'(w_push);
         r_count  <= r_count - CW'(w_take) + CW'(w_push);
      end
   end

   // Storage is never cleared; occupancy alone decides what is visible.
   always_ff @(posedge i_clk) begin
      if (!i_rst && !i_flush && (w_push != 2'd0)) begin
         r_instr[r_wr_ptr] <= i_fetch_instr1;
         r_pc[r_wr_ptr]    <= i_fetch_pc;
         if (w_push == 2'd2) begin
            r_instr[w_wr_ptr_p1] <= i_fetch_instr2;
            r_pc[w_wr_ptr_p1]    <= i_fetch_pc + 32'd4;
         end
      end
   end

   always_comb begin
      o_fetch_ready    = w_ready;
      o_count          = r_count;
      o_valid_d1       = (r_count >= CW'(1));
      o_valid_d2       = (r_count >= CW'(2));
      o_instruction_d1 = o_valid_d1 ? r_instr[r_rd_ptr]    : NOP_WORD;
      o_pc_d1          = o_valid_d1 ? r_pc[r_rd_ptr]       : 32'd0;
      o_instruction_d2 = o_valid_d2 ? r_instr[w_rd_ptr_p1] : NOP_WORD;
      o_pc_d2          = o_valid_d2 ? r_pc[w_rd_ptr_p1]    : 32'd0;
   end

endmodule

// File: tb/tb_dual_issue_fetch_queue.sv
// Bench for dual_issue_fetch_queue: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_dual_issue_fetch_queue;

   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic [1:0]  fetch_valid;
   logic [31:0] fetch_instr1;
   logic [31:0] fetch_instr2;
   logic [31:0] fetch_pc;
   logic        fetch_ready;
   logic [1:0]  issue_take;
   logic        flush;
   logic [31:0] instr_d1;
   logic [31:0] instr_d2;
   logic [31:0] pc_d1;
   logic [31:0] pc_d2;
   logic        valid_d1;
   logic        valid_d2;
   logic [3:0]  count;

   int n_pass  = 0;
   int n_total = 0;
   bit check_en = 0;

   logic [63:0] model_q[$];

   dual_issue_fetch_queue #(
      .DEPTH   (DEPTH),
      .NOP_WORD(NOP)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_fetch_valid   (fetch_valid),
      .i_fetch_instr1  (fetch_instr1),
      .i_fetch_instr2  (fetch_instr2),
      .i_fetch_pc      (fetch_pc),
      .o_fetch_ready   (fetch_ready),
      .i_issue_take    (issue_take),
      .i_flush         (flush),
      .o_instruction_d1(instr_d1),
      .o_instruction_d2(instr_d2),
      .o_pc_d1         (pc_d1),
      .o_pc_d2         (pc_d2),
      .o_valid_d1      (valid_d1),
      .o_valid_d2      (valid_d2),
      .o_count         (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model: a plain queue of {instr, pc}, updated from the rules on each edge.
   initial begin
      int n;
      int tk;
      bit rdy;
      forever begin
         @(posedge clk);
         n   = model_q.size();
         rdy = (DEPTH - n) >= 2;
         tk  = (issue_take == 2'd3) ? 2 : int'(issue_take);
         if (tk > n) tk = n;
         if (rst || flush) begin
            model_q.delete();
         end else begin
            repeat (tk) void'(model_q.pop_front());
            if (rdy && fetch_valid[0]) begin
               model_q.push_back({fetch_instr1, fetch_pc});
               if (fetch_valid[1]) model_q.push_back({fetch_instr2, fetch_pc + 32'd4});
            end
         end
      end
   end

   initial begin
      int n;
      forever begin
         @(negedge clk);
         if (check_en) begin
            n = model_q.size();
            chk("m_count", 32'(count), 32'(n));
            chk("m_ready", 32'(fetch_ready), 32'((DEPTH - n) >= 2));
            chk("m_valid_d1", 32'(valid_d1), 32'(n >= 1));
            chk("m_valid_d2", 32'(valid_d2), 32'(n >= 2));
            chk("m_instr_d1", instr_d1, (n >= 1) ? model_q[0][63:32] : NOP);
            chk("m_pc_d1", pc_d1, (n >= 1) ? model_q[0][31:0] : 32'd0);
            chk("m_instr_d2", instr_d2, (n >= 2) ? model_q[1][63:32] : NOP);
            chk("m_pc_d2", pc_d2, (n >= 2) ? model_q[1][31:0] : 32'd0);
         end
      end
   end

   task automatic cyc(input logic r, input logic f, input logic [1:0] v, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] p, input logic [1:0] t);
      rst          = r;
      flush        = f;
      fetch_valid  = v;
      fetch_instr1 = a;
      fetch_instr2 = b;
      fetch_pc     = p;
      issue_take   = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset
      cyc(1, 0, 2'b11, 32'h1111_1111, 32'h2222_2222, 32'h40, 2'd2);
      check_en = 1;
      chk("rst_count", 32'(count), 0);
      chk("rst_valid_d1", 32'(valid_d1), 0);
      chk("rst_valid_d2", 32'(valid_d2), 0);
      chk("rst_instr_d1", instr_d1, NOP);
      chk("rst_instr_d2", instr_d2, NOP);
      chk("rst_pc_d1", pc_d1, 0);
      chk("rst_ready", 32'(fetch_ready), 1);

      // Take on empty is ignored
      cyc(0, 0, 2'b00, 0, 0, 0, 2'd2);
      chk("empty_take_count", 32'(count), 0);

      // Basic pair then take 2
      cyc(0, 0, 2'b11, 32'h2008_0001, 32'h2009_0002, 32'h0, 2'd0);
      chk("pair_count", 32'(count), 2);
      chk("pair_d1", instr_d1, 32'h2008_0001);
      chk("pair_d2", instr_d2, 32'h2009_0002);
      chk("pair_pc_d1", pc_d1, 32'h0);
      chk("pair_pc_d2", pc_d2, 32'h4);
      cyc(0, 0, 2'b00, 0, 0, 0, 2'd2);
      chk("pair_drain_count", 32'(count), 0);

      // Split issue keeps B at head, followed by C
      cyc(0, 0, 2'b11, 32'h0000_000A, 32'h0000_000B, 32'h100, 2'd0);
      cyc(0, 0, 2'b11, 32'h0000_000C, 32'h0000_000D, 32'h200, 2'd1);
      chk("split_count", 32'(count), 3);
      chk("split_d1", instr_d1, 32'h0000_000B);
      chk("split_pc_d1", pc_d1, 32'h104);
      chk("split_d2", instr_d2, 32'h0000_000C);
      chk("split_pc_d2", pc_d2, 32'h200);
      cyc(0, 0, 2'b00, 0, 0, 0, 2'd2);
      chk("split_tail_d1", instr_d1, 32'h0000_000D);
      cyc(0, 0, 2'b00, 0, 0, 0, 2'd3);
      chk("count1_take2", 32'(count), 0);

      // Fill to full, then an overflow attempt
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, 2'b11, 32'h3000_0000 + 32'(2 * k), 32'h3000_0001 + 32'(2 * k),
             32'h1000 + 32'(8 * k), 2'd0);
      end
      chk("full_count", 32'(count), 8);
      chk("full_ready", 32'(fetch_ready), 0);
      cyc(0, 0, 2'b11, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h9000, 2'd0);
      chk("overflow_count", 32'(count), 8);
      chk("overflow_d1", instr_d1, 32'h3000_0000);
      // Push with take 2 while full: push dropped, then steady state at DEPTH-2
      for (int k = 0; k < 10; k++) begin
         cyc(0, 0, 2'b11, 32'h4000_0000 + 32'(2 * k), 32'h4000_0001 + 32'(2 * k),
             32'h2000 + 32'(8 * k), 2'd2);
      end
      chk("wrap_count", 32'(count), 6);
      cyc(0, 0, 2'b11, 32'h5000_0000, 32'h5000_0001, 32'h3000, 2'd0);
      chk("dm2_push_take0", 32'(count), 8);
      for (int k = 0; k < 4; k++) cyc(0, 0, 2'b00, 0, 0, 0, 2'd2);
      chk("drain_count", 32'(count), 0);

      // Single-valid pushes
      cyc(0, 0, 2'b01, 32'h6000_0000, 32'h6000_0001, 32'h500, 2'd0);
      chk("v01_count", 32'(count), 1);
      chk("v01_valid_d2", 32'(valid_d2), 0);
      cyc(0, 0, 2'b10, 32'h6100_0000, 32'h6100_0001, 32'h600, 2'd0);
      chk("v10_count", 32'(count), 1);
      cyc(0, 0, 2'b00, 0, 0, 0, 2'd2);

      // Flush at count 5 with push and take
      cyc(0, 0, 2'b11, 32'h7000_0000, 32'h7000_0001, 32'h700, 2'd0);
      cyc(0, 0, 2'b11, 32'h7000_0002, 32'h7000_0003, 32'h708, 2'd0);
      cyc(0, 0, 2'b01, 32'h7000_0004, 32'h7000_0005, 32'h710, 2'd0);
      chk("pre_flush_count", 32'(count), 5);
      cyc(0, 1, 2'b11, 32'h7100_0000, 32'h7100_0001, 32'h800, 2'd1);
      chk("flush_count", 32'(count), 0);
      chk("flush_valid_d1", 32'(valid_d1), 0);
      chk("flush_instr_d1", instr_d1, NOP);

      // Reset mid-operation
      cyc(0, 0, 2'b11, 32'h7200_0000, 32'h7200_0001, 32'h900, 2'd0);
      cyc(1, 0, 2'b11, 32'h7300_0000, 32'h7300_0001, 32'hA00, 2'd1);
      chk("midrst_count", 32'(count), 0);
      chk("midrst_ready", 32'(fetch_ready), 1);

      // Random traffic against the model
      for (int k = 0; k < 10000; k++) begin
         cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 31) == 0),
             2'($urandom_range(0, 3)), $urandom, $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
             2'($urandom_range(0, 3)));
      end

      check_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dual_issue_fetch_queue.md
# dual_issue_fetch_queue

Instruction-granular FIFO between the dual-fetch stage and the two-lane issue logic of the 2-way in-order superscalar MIPS core. Accepts up to two sequential instructions per cycle from fetch and presents the two oldest entries as lane-1 and lane-2 decode instructions. The issue logic can consume 0, 1 or 2 instructions per cycle, so a pair split by a dependency or a swap keeps the unissued instruction at the head. A branch or jump flush empties the queue in one cycle.

## Interface
Parameters:
- DEPTH, 8, number of instruction slots; power of two, ≥ 4
- NOP_WORD, 32'h0000_0000, word driven on an empty lane; opcode RT with rd = 0, so it carries no register dependency

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- fetch_valid  in  2  [0] = fetch_instr1 valid, [1] = fetch_instr2 valid; [1] is ignored when [0] = 0
- fetch_instr1  in  32  older fetched instruction
- fetch_instr2  in  32  younger fetched instruction, located at fetch_pc + 4
- fetch_pc  in  32  PC of fetch_instr1
- fetch_ready  out  1  queue can accept a full pair this cycle
- issue_take  in  2  number of head instructions consumed this cycle; 3 is treated as 2
- flush  in  1  discard all entries (branch taken or jump)
- instruction_D1 / instruction_D2  out  32  oldest / second-oldest entry, or NOP_WORD if absent
- pc_D1 / pc_D2  out  32  PCs of those entries, 0 if absent
- valid_D1 / valid_D2  out  1  entry present
- count  out  log2(DEPTH)+1  occupied slots

## Operation
- Storage: DEPTH × {instr[31:0], pc[31:0]}, with a read pointer and a write pointer of log2(DEPTH) bits, both wrapping modulo DEPTH, plus an occupancy counter.
- push = 0 if fetch_ready = 0 or fetch_valid[0] = 0; otherwise 1 + fetch_valid[1].
- On push, fetch_instr1/fetch_pc go to slot wr, and fetch_instr2/fetch_pc+4 go to slot wr+1 (mod DEPTH). The write pointer advances by push.
- take_eff = min(issue_take clipped to 2, count). The read pointer advances by take_eff.
- Next count = count − take_eff + push. The count never exceeds DEPTH and never goes below 0.
- fetch_ready = (DEPTH − count) ≥ 2. It uses the current count only and does not credit same-cycle takes.
- Output lanes:
  - valid_D1 = count ≥ 1; valid_D2 = count ≥ 2.
  - instruction_D1 reads slot rd and instruction_D2 reads slot rd+1; each shows NOP_WORD with pc 0 when its lane is invalid.
- Flush has priority over everything: both pointers and count go to 0, and that cycle's push and take are discarded.
- rst behaves identically to flush, and the storage contents need not be cleared.
- Program order is strictly preserved: lane 1 is always older than lane 2. Lane swapping is the issue logic's job, never the queue's.

## Timing
- Reset values:
  - count = 0, valid_D1 = valid_D2 = 0
  - instruction_D1 = instruction_D2 = NOP_WORD, pc_D1 = pc_D2 = 0
  - fetch_ready = 1
- Outputs are combinational from registered state only. There is no path from fetch inputs or issue_take to the D outputs in the same cycle.
- Latency: a pair pushed at edge N appears on the D lanes after edge N when the queue was empty, and becomes visible the cycle after the take that exposes it otherwise.
- Simultaneous push and take with count = DEPTH − 2:
  - fetch_ready = 1, so the push is accepted.
  - With take = 2 the next count is DEPTH − 2; with take = 0 it is DEPTH.
- Full (count = DEPTH) or count = DEPTH − 1: fetch_ready = 0, and fetch_valid is ignored even if a take occurs in the same cycle.
- Empty: issue_take is ignored.
- count = 1 with take = 2: only one entry is consumed.
- Flush and push in the same cycle: the queue is empty after the edge. Fetch must re-present the redirected instructions the next cycle.
- Reset asserted mid-operation: the queue is empty after that edge regardless of the other inputs.

## Test plan
- Reset, then push pairs {0x20080001, 0x20090002} at pc 0x0, then take 2 → D1/D2 show these words with pc 0x0/0x4 one cycle after the push; count goes 0 → 2 → 0.
- Split issue: push pairs A,B then C,D, and take 1 on the first pair → the next cycle D1 = B, D2 = C, count = 3, program order preserved.
- Fill and wrap (DEPTH = 8): four pushes with no takes → count = 8, fetch_ready = 0, and a fifth push is dropped. Then alternate take 2 with a push of 2 for 10 cycles → pointers wrap and FIFO order matches the reference model.
- Single-valid push: fetch_valid = 2'b01 and 2'b10 → the first adds 1 entry, the second adds 0 entries.
- Flush at count = 5 with simultaneous push and take 1 → the next cycle count = 0, valid_D1 = 0, instruction_D1 = NOP_WORD.
- Random push/take/flush for 10k cycles against a scoreboard model → no overflow, no underflow, and D lanes always equal the two oldest model entries.
